// File: rtl/machine_input_frontend.sv
// machine_input_frontend: board switch/button conditioning for Machine_mealy.w2.
// Each raw pin is synchronised with two flops into the system1000 domain and then
// debounced independently. Optional build macro MACHINE_FRONTEND_PULSE_EN turns
// accepted button presses into single-cycle pulses on w2[3:0]; without it w2[3:0]
// carries the debounced button levels.
module machine_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       system1000,
    input  logic       system1000_rstn,
    input  logic [3:0] sw_raw,
    input  logic [3:0] btn_raw,
    output logic [7:0] w2,
    output logic [3:0] btn_level,
    output logic       changed
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Bit order matches w2: switches in the upper nibble, buttons in the lower.
    logic [7:0]       raw;
    logic [7:0]       s1;
    logic [7:0]       s2;
    logic [7:0]       stable;
    logic [7:0]       accept;
    logic [CNT_W-1:0] cnt [8];
    logic [3:0]       btn_stage;

    assign raw = {sw_raw, btn_raw};

    // Two-flop synchroniser for all eight asynchronous pins.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A bit is accepted on the edge that completes DEBOUNCE_CYCLES differing samples.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 8; i++) begin
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit debounce: any sample equal to the accepted value restarts the count.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            stable <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef MACHINE_FRONTEND_PULSE_EN
    logic [3:0] btn_prev;
    logic [3:0] press;

    // Previous accepted button levels; a rising accepted level is a press.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= stable[3:0];
        end
    end

    // Releases clear the level but never produce a pulse.
    assign press     = stable[3:0] & ~btn_prev;
    assign btn_stage = press;
`else
    assign btn_stage = stable[3:0];
`endif

    // Output register. w2[7:4] and btn_level hold last edge's accepted values, so
    // comparing them with the current accepted bits detects a flip on the previous edge.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            w2        <= '0;
            btn_level <= '0;
            changed   <= 1'b0;
        end else begin
            w2        <= {stable[7:4], btn_stage};
            btn_level <= stable[3:0];
            changed   <= |(stable ^ {w2[7:4], btn_level});
        end
    end

endmodule

// File: tb/tb_machine_input_frontend.sv
// Testbench for machine_input_frontend: directed scenarios plus randomized pin
// activity, checked every cycle against a sample-window reference model through a
// scoreboard queue. Build with MACHINE_FRONTEND_PULSE_EN to check the pulse mode.
module tb_machine_input_frontend;

    localparam int D = 4;

    logic       clk;
    logic       rstn;
    logic [3:0] sw_raw;
    logic [3:0] btn_raw;
    logic [7:0] w2;
    logic [3:0] btn_level;
    logic       changed;

    int tests;
    int fails;

    machine_input_frontend #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20)
    ) dut (
        .system1000(clk),
        .system1000_rstn(rstn),
        .sw_raw(sw_raw),
        .btn_raw(btn_raw),
        .w2(w2),
        .btn_level(btn_level),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    logic [12:0] sb[$];
    logic [7:0]  hist[$];   // synchronised samples seen since reset, newest last
    logic [7:0]  m_p1, m_p2;
    logic [7:0]  m_acc;     // accepted value after the latest edge
    logic [7:0]  m_accq;    // accepted value one edge earlier

    task automatic model_step();
        logic [7:0] e_w2;
        logic [3:0] e_bl;
        logic       e_ch;
        logic [7:0] nxt;
        logic       all_diff;
        if (!rstn) begin
            m_p1 = '0; m_p2 = '0; m_acc = '0; m_accq = '0;
            hist.delete();
            sb.push_back(13'h0);
        end else begin
            e_ch = (m_acc != m_accq);
`ifdef MACHINE_FRONTEND_PULSE_EN
            e_w2 = {m_acc[7:4], m_acc[3:0] & ~m_accq[3:0]};
`else
            e_w2 = m_acc;
`endif
            e_bl = m_acc[3:0];
            // A bit changes when the last D synchronised samples all disagree with it.
            hist.push_back(m_p2);
            if (hist.size() > D) void'(hist.pop_front());
            nxt = m_acc;
            if (hist.size() == D) begin
                for (int b = 0; b < 8; b++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (hist[j][b] == m_acc[b]) all_diff = 1'b0;
                    if (all_diff) nxt[b] = ~m_acc[b];
                end
            end
            m_accq = m_acc;
            m_acc  = nxt;
            m_p2   = m_p1;
            m_p1   = {sw_raw, btn_raw};
            sb.push_back({e_w2, e_bl, e_ch});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compare the registered outputs mid-cycle against the queued expectation.
    initial begin
        logic [12:0] exp_v;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                tests++;
                if ({w2, btn_level, changed} !== exp_v) begin
                    fails++;
                    $display("FAIL outputs @%0t: got w2=%h btn_level=%h changed=%b, expected w2=%h btn_level=%h changed=%b",
                             $time, w2, btn_level, changed, exp_v[12:5], exp_v[4:1], exp_v[0]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [3:0] s, input logic [3:0] b);
        @(negedge clk);
        #1;
        sw_raw  = s;
        btn_raw = b;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts rising edges after an input change until w2[idx] rises; must be edge 7.
    task automatic check_rise(input int idx, input string nm);
        int e;
        e = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (w2[idx]) begin
                e = k;
                break;
            end
        end
        tests++;
        if (e != D + 3) begin
            fails++;
            $display("FAIL %s: w2[%0d] rose at edge %0d, expected edge %0d (0 = never)", nm, idx, e, D + 3);
        end
    endtask

    initial begin
        logic [7:0] v;
        int         k;
        tests   = 0;
        fails   = 0;
        rstn    = 1'b0;
        sw_raw  = 4'hF;
        btn_raw = 4'hF;

        // 1: everything high through reset, then release with pins held.
        idle(5);
        #1;
        rstn = 1'b1;
        idle(12);

        // 2: single switch rise, latency check.
        set_in(4'h0, 4'h0);
        idle(12);
        set_in(4'h4, 4'h0);
        check_rise(6, "sw2_latency");
        idle(6);

        // 3: button 0 bounce with 1-cycle glitches, then held.
        set_in(4'h4, 4'h1);
        set_in(4'h4, 4'h0);
        set_in(4'h4, 4'h1);
        set_in(4'h4, 4'h0);
        set_in(4'h4, 4'h1);
        idle(14);

        // 4: long hold of button 1 and release.
        set_in(4'h4, 4'h3);
        idle(50);
        set_in(4'h4, 4'h1);
        idle(12);

        // 5: switch 0 and button 3 on the same edge.
        set_in(4'h5, 4'h9);
        idle(12);

        // 6: reset during a pending switch 1 count, then full recount.
        set_in(4'h7, 4'h9);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        idle(2);
        #1;
        rstn = 1'b1;
        check_rise(5, "sw1_recount_after_reset");
        idle(10);

        // Randomized pin activity: occasional single-bit flips give both glitches and
        // long holds; a short reset is dropped in periodically.
        for (int c = 0; c < 1500; c++) begin
            v = {sw_raw, btn_raw};
            if ($urandom_range(0, 15) < 3) begin
                k = $urandom_range(0, 7);
                v[k] = ~v[k];
            end
            @(negedge clk);
            #1;
            sw_raw  = v[7:4];
            btn_raw = v[3:0];
            rstn    = ((c % 400) != 399);
        end
        #1;
        rstn = 1'b1;
        idle(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
